// File: rtl/phase_kick_gen.sv
// phase_kick_gen: turns the gradient counter's level-sensitive stall flag
// into a bounded pseudo-random phase perturbation on one node's phase word.
// A trigger latches an offset from a free-running 16-bit Galois LFSR. The
// offset is added to phase_in for KICK_CYCLES cycles. A COOLDOWN window then
// blocks new triggers.
// Optional feature: define PHASE_KICK_STATS_EN to build the saturating
// accepted-kick counter on kick_count; otherwise kick_count is tied to 0.
module phase_kick_gen #(
    parameter int unsigned PHASE_W     = 8,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned KICK_CYCLES = 4,
    parameter int unsigned COOLDOWN    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ena,
    input  logic               random_self_phase,
    input  logic [PHASE_W-1:0] phase_in,
    output logic [PHASE_W-1:0] phase_out,
    output logic               kick_active,
    output logic [15:0]        kick_count
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [15:0]        SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]        KICK_LOAD = 16'(KICK_CYCLES - 1);
    localparam logic [15:0]        COOL_LOAD = 16'(COOLDOWN - 1);
    localparam logic [PHASE_W-1:0] HALF_TURN = {1'b1, {(PHASE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_KICK,
        S_COOL
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PHASE_W-1:0] offset_q, offset_d;
    logic [PHASE_W-1:0] phase_out_q, phase_out_d;
    logic               kick_active_q, kick_active_d;
    logic               rearm_ok;
    logic               accept;

    // Galois right-shift step, taps 0xB400; never reaches zero from a nonzero state.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // A zero low slice would be a no-op kick, so it becomes a half turn instead.
    function automatic logic [PHASE_W-1:0] pick_offset(input logic [15:0] s);
        if (s[PHASE_W-1:0] == '0) begin
            return HALF_TURN;
        end
        return s[PHASE_W-1:0];
    endfunction

    // Phase wraps modulo 2^PHASE_W; the carry is dropped on purpose.
    function automatic logic [PHASE_W-1:0] phase_add(input logic [PHASE_W-1:0] a,
                                                      input logic [PHASE_W-1:0] b);
        return a + b;
    endfunction

    // The last cooldown edge (or the last kick edge when COOLDOWN is 0)
    // already behaves as IDLE. A held trigger is therefore re-accepted
    // exactly KICK_CYCLES+COOLDOWN edges after the previous one.
    assign rearm_ok = (state_q == S_IDLE)
                   || ((state_q == S_COOL) && (cnt_q == 16'd0))
                   || ((state_q == S_KICK) && (cnt_q == 16'd0) && (COOLDOWN == 0));
    assign accept   = ena && random_self_phase && rearm_ok;

    // LFSR advances only on enabled edges.
    assign lfsr_d = ena ? lfsr_next(lfsr_q) : lfsr_q;

    // Next-state, counters and registered outputs; passthrough is the default.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        offset_d      = offset_q;
        kick_active_d = 1'b0;
        phase_out_d   = phase_in;
        if (!ena) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
        end else if (accept) begin
            state_d       = S_KICK;
            cnt_d         = KICK_LOAD;
            offset_d      = pick_offset(lfsr_q);
            kick_active_d = 1'b1;
            phase_out_d   = phase_add(phase_in, pick_offset(lfsr_q));
        end else begin
            case (state_q)
                S_KICK: begin
                    if (cnt_q == 16'd0) begin
                        if (COOLDOWN == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_COOL;
                            cnt_d   = COOL_LOAD;
                        end
                    end else begin
                        cnt_d         = cnt_q - 16'd1;
                        kick_active_d = 1'b1;
                        phase_out_d   = phase_add(phase_in, offset_q);
                    end
                end
                S_COOL: begin
                    if (cnt_q == 16'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, LFSR, latched offset and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= 16'd0;
            lfsr_q        <= SEED_EFF;
            offset_q      <= '0;
            phase_out_q   <= '0;
            kick_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lfsr_q        <= lfsr_d;
            offset_q      <= offset_d;
            phase_out_q   <= phase_out_d;
            kick_active_q <= kick_active_d;
        end
    end

    assign phase_out   = phase_out_q;
    assign kick_active = kick_active_q;

`ifdef PHASE_KICK_STATS_EN
    logic [15:0] kick_count_q, kick_count_d;

    // Saturating count of accepted triggers.
    always_comb begin
        kick_count_d = kick_count_q;
        if (accept && (kick_count_q != 16'hFFFF)) begin
            kick_count_d = kick_count_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kick_count_q <= 16'd0;
        end else begin
            kick_count_q <= kick_count_d;
        end
    end

    assign kick_count = kick_count_q;
`else
    assign kick_count = 16'h0000;
`endif

endmodule

// File: tb/tb_phase_kick_gen.sv
// Bench for phase_kick_gen: three instances (default, zero-low-byte seed,
// KICK_CYCLES=1/COOLDOWN=0) checked every cycle against a time-window model,
// plus literal expectations for the documented scenarios.
module tb_phase_kick_gen;

    logic       clk;
    logic       reset_n;
    logic       ena_s [3];
    logic       rsp_s [3];
    logic [7:0] pin_s [3];
    logic [7:0] po    [3];
    logic       ka    [3];
    logic [15:0] kc   [3];

    int checks = 0;
    int errors = 0;

    phase_kick_gen u_dut0 (
        .clk(clk), .reset_n(reset_n), .ena(ena_s[0]), .random_self_phase(rsp_s[0]),
        .phase_in(pin_s[0]), .phase_out(po[0]), .kick_active(ka[0]), .kick_count(kc[0])
    );

    phase_kick_gen #(.SEED(16'h0100)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .ena(ena_s[1]), .random_self_phase(rsp_s[1]),
        .phase_in(pin_s[1]), .phase_out(po[1]), .kick_active(ka[1]), .kick_count(kc[1])
    );

    phase_kick_gen #(.KICK_CYCLES(1), .COOLDOWN(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .ena(ena_s[2]), .random_self_phase(rsp_s[2]),
        .phase_in(pin_s[2]), .phase_out(po[2]), .kick_active(ka[2]), .kick_count(kc[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each instance is described by time windows
    // (kick ends at edge m_kend, next trigger allowed from edge m_next).
    int          K_m    [3] = '{4, 4, 1};
    int          C_m    [3] = '{16, 16, 0};
    logic [15:0] seed_m [3] = '{16'hACE1, 16'h0100, 16'hACE1};
    logic [15:0] m_lfsr [3];
    logic [7:0]  m_off  [3];
    longint      m_edge [3];
    longint      m_kend [3];
    longint      m_next [3];
    int          m_cnt  [3];
    logic [7:0]  m_phase[3];
    logic        m_act  [3];

    function automatic int expc(input int n);
`ifdef PHASE_KICK_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_lfsr[i]  = seed_m[i];
            m_off[i]   = 8'h00;
            m_edge[i]  = 0;
            m_kend[i]  = -1;
            m_next[i]  = 0;
            m_cnt[i]   = 0;
            m_phase[i] = 8'h00;
            m_act[i]   = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!ena_s[i]) begin
                m_phase[i] = pin_s[i];
                m_act[i]   = 1'b0;
                m_kend[i]  = -1;
                m_next[i]  = 0;
            end else begin
                if (rsp_s[i] && (m_edge[i] >= m_next[i])) begin
                    m_off[i]  = (m_lfsr[i][7:0] == 8'h00) ? 8'h80 : m_lfsr[i][7:0];
                    m_kend[i] = m_edge[i] + K_m[i] - 1;
                    m_next[i] = m_edge[i] + K_m[i] + C_m[i];
                    if (m_cnt[i] < 65535) m_cnt[i]++;
                end
                m_act[i]   = (m_edge[i] <= m_kend[i]);
                m_phase[i] = m_act[i] ? 8'(pin_s[i] + m_off[i]) : pin_s[i];
                m_lfsr[i]  = m_lfsr[i][0] ? ((m_lfsr[i] >> 1) ^ 16'hB400) : (m_lfsr[i] >> 1);
            end
            m_edge[i]++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_phase_out[%0d]", i), 32'(po[i]), 32'(m_phase[i]));
                chk($sformatf("model_kick_active[%0d]", i), 32'(ka[i]), 32'(m_act[i]));
                chk($sformatf("model_kick_count[%0d]", i), 32'(kc[i]), 32'(expc(m_cnt[i])));
            end
        end
    end

    logic [7:0] seq2 [5] = '{8'hE1, 8'h70, 8'h38, 8'h9C, 8'h4E};
    int rise_at [4];

    initial begin
        int rises;
        logic prev;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ena_s[i] = 1'b0;
            rsp_s[i] = 1'b0;
            pin_s[i] = 8'h55;
        end
        repeat (2) @(negedge clk);
        chk("reset_phase_out", 32'(po[0]), 32'h0);
        chk("reset_kick_active", 32'(ka[0]), 32'h0);
        chk("reset_kick_count", 32'(kc[0]), 32'h0);
        reset_n = 1'b1;

        // Scenario A: enable and trigger on the same edge after idling disabled.
        repeat (3) @(negedge clk);
        chk("disabled_passthrough", 32'(po[0]), 32'h55);
        ena_s[0] = 1'b1; rsp_s[0] = 1'b1; pin_s[0] = 8'h30;
        ena_s[1] = 1'b1; rsp_s[1] = 1'b1; pin_s[1] = 8'h90;
        ena_s[2] = 1'b1; rsp_s[2] = 1'b1; pin_s[2] = 8'h00;
        @(negedge clk);
        chk("first_kick_phase", 32'(po[0]), 32'h11);
        chk("first_kick_active", 32'(ka[0]), 32'h1);
        chk("first_kick_count", 32'(kc[0]), 32'(expc(1)));
        chk("model_lfsr_after", 32'(m_lfsr[0]), 32'hE270);
        chk("dut_lfsr_after", 32'(u_dut0.lfsr_q), 32'hE270);
        chk("half_turn_phase", 32'(po[1]), 32'h10);
        chk("fast_seq0", 32'(po[2]), 32'(seq2[0]));
        rsp_s[0] = 1'b0; rsp_s[1] = 1'b0;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            chk($sformatf("kick_hold_phase_%0d", j), 32'(po[0]), 32'h11);
            chk($sformatf("kick_hold_active_%0d", j), 32'(ka[0]), 32'h1);
            chk($sformatf("fast_seq%0d", j), 32'(po[2]), 32'(seq2[j]));
            chk($sformatf("fast_active_%0d", j), 32'(ka[2]), 32'h1);
        end
        @(negedge clk);
        chk("kick_end_active", 32'(ka[0]), 32'h0);
        chk("kick_end_phase", 32'(po[0]), 32'h30);
        chk("fast_seq4", 32'(po[2]), 32'(seq2[4]));

        // Scenario B: trigger held high from a fresh reset.
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ena_s[i] = 1'b0; rsp_s[i] = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        ena_s[0] = 1'b1; rsp_s[0] = 1'b1;
        rises = 0; prev = 1'b0;
        for (int c = 0; c < 45; c++) begin
            pin_s[0] = 8'(c * 7);
            @(negedge clk);
            if (ka[0] && !prev) begin
                if (rises < 4) rise_at[rises] = c;
                rises++;
                if (rises == 3) chk("held_count_third", 32'(kc[0]), 32'(expc(3)));
            end
            prev = ka[0];
        end
        chk("held_rises", 32'(rises), 32'd3);
        chk("held_gap1", 32'(rise_at[1] - rise_at[0]), 32'd20);
        chk("held_gap2", 32'(rise_at[2] - rise_at[1]), 32'd20);

        // Scenario D: drop ena during the second kick cycle.
        ena_s[0] = 1'b0; rsp_s[0] = 1'b0;
        @(negedge clk);
        ena_s[0] = 1'b1; rsp_s[0] = 1'b1; pin_s[0] = 8'h44;
        @(negedge clk);
        chk("drop_kick1_active", 32'(ka[0]), 32'h1);
        rsp_s[0] = 1'b0;
        @(negedge clk);
        chk("drop_kick2_active", 32'(ka[0]), 32'h1);
        ena_s[0] = 1'b0; pin_s[0] = 8'h5A;
        @(negedge clk);
        chk("drop_active", 32'(ka[0]), 32'h0);
        chk("drop_phase", 32'(po[0]), 32'h5A);
        ena_s[0] = 1'b1; rsp_s[0] = 1'b1; pin_s[0] = 8'h12;
        @(negedge clk);
        chk("reenable_kick", 32'(ka[0]), 32'h1);

        // Scenario E: asynchronous reset in the middle of the cooldown.
        rsp_s[0] = 1'b0; pin_s[0] = 8'h77;
        repeat (6) @(negedge clk);
        chk("cool_phase_before_reset", 32'(po[0]), 32'h77);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_phase", 32'(po[0]), 32'h0);
        chk("async_reset_active", 32'(ka[0]), 32'h0);
        chk("async_reset_count", 32'(kc[0]), 32'h0);
        ena_s[0] = 1'b1; rsp_s[0] = 1'b1; pin_s[0] = 8'h20;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_kick", 32'(ka[0]), 32'h1);
        chk("post_reset_phase", 32'(po[0]), 32'h01);

        // Randomized stimulus, all instances, with two asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                ena_s[i] = ($urandom_range(0, 15) != 0);
                rsp_s[i] = ($urandom_range(0, 3) == 0) || (c % 200 < 30);
                pin_s[i] = 8'($urandom);
            end
            if (c == 1000 || c == 2000) begin
                @(posedge clk);
                #3;
                reset_n = 1'b0;
                #1;
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("rand_reset_phase[%0d]", i), 32'(po[i]), 32'h0);
                    chk($sformatf("rand_reset_active[%0d]", i), 32'(ka[i]), 32'h0);
                end
                @(negedge clk);
                reset_n = 1'b1;
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
